// File: rtl/server_core.sv
// Server-side frame responder: authenticates a 16-bit frame against a key, computes
// payload*MULT+OFFSET with a shift-add engine and returns it with a one-cycle strobe.
module server_core #(
  parameter logic [6:0] AUTH_KEY = 7'h5A,
  parameter logic [7:0] MULT     = 8'd3,
  parameter logic [7:0] OFFSET   = 8'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] frame_in,
  output logic        auth_done,
  output logic [7:0]  processed_data,
  output logic        write_back_en,
  output logic        busy,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AUTH = 2'd1,
    S_PROC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        auth_done_q, auth_done_d;
  logic [7:0]  data_q, data_d;
  logic        wb_q, wb_d;
  logic        busy_q, busy_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  fail_q, fail_d;
  logic        auth_pass;
  logic [7:0]  payload_shifted;

  assign auth_pass       = (frame_q[15] == 1'b0) && (frame_q[14:8] == AUTH_KEY);
  assign payload_shifted = frame_q[7:0] << bit_cnt_q;

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    auth_done_d = auth_done_q;
    data_d      = data_q;
    wb_d        = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d = frame_in;
          state_d = S_AUTH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AUTH: begin
        if (auth_pass) begin
          acc_d     = OFFSET;
          bit_cnt_d = 3'd0;
          state_d   = S_PROC;
        end else begin
          auth_done_d = 1'b0;
          data_d      = 8'h00;
          wb_d        = 1'b1;
          fail_d      = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      S_PROC: begin
        if (MULT[bit_cnt_q]) begin
          acc_d = acc_q + payload_shifted;
        end else begin
          acc_d = acc_q;
        end
        if (bit_cnt_q == 3'd7) begin
          auth_done_d = 1'b1;
          data_d      = acc_d;
          wb_d        = 1'b1;
          pass_d      = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          state_d     = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= 16'h0000;
      acc_q       <= 8'h00;
      bit_cnt_q   <= 3'd0;
      auth_done_q <= 1'b0;
      data_q      <= 8'h00;
      wb_q        <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 8'h00;
      fail_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      auth_done_q <= auth_done_d;
      data_q      <= data_d;
      wb_q        <= wb_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign auth_done      = auth_done_q;
  assign processed_data = data_q;
  assign write_back_en  = wb_q;
  assign busy           = busy_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;

endmodule
